a2bus_sampler: RTL

Parametrised Apple II bus sampler, second generation of the slot-bus front end. It tracks the Phi1 phase itself, latches address and R/W at a programmable point in Phi1, and takes N spaced data samples in Phi0 with a consistency check. It also reports short-phase glitches, bus-cycle count and sleep. It sits between the pin synchronisers and the a2bus_if fan-out, in the clk_logic domain.

---
 rtl/a2bus_sampler_if.sv | 34 +++
 rtl/a2bus_sampler.sv | 138 +++++++++++++
 2 files changed

// File: rtl/a2bus_sampler_if.sv
// Slot-bus pin bundle and sampled results exchanged between the pin
// synchronisers (master side) and a2bus_sampler (slave side).
interface a2bus_sampler_if;
    logic        a2_phi1_i;
    logic [15:0] a2_a_i;
    logic [7:0]  a2_d_i;
    logic        a2_rw_n_i;

    logic [15:0] addr_o;
    logic        rw_n_o;
    logic        addr_strobe_o;
    logic [7:0]  data_o;
    logic        data_in_strobe_o;
    logic        data_stable_o;
    logic        glitch_o;
    logic [7:0]  glitch_count_o;
    logic [31:0] cycle_count_o;
    logic        phase_o;
    logic        sleep_o;

    modport master (
        output a2_phi1_i, a2_a_i, a2_d_i, a2_rw_n_i,
        input  addr_o, rw_n_o, addr_strobe_o, data_o, data_in_strobe_o,
        input  data_stable_o, glitch_o, glitch_count_o, cycle_count_o,
        input  phase_o, sleep_o
    );

    modport slave (
        input  a2_phi1_i, a2_a_i, a2_d_i, a2_rw_n_i,
        output addr_o, rw_n_o, addr_strobe_o, data_o, data_in_strobe_o,
        output data_stable_o, glitch_o, glitch_count_o, cycle_count_o,
        output phase_o, sleep_o
    );
endinterface

// File: rtl/a2bus_sampler.sv
// Apple II slot-bus sampler: tracks Phi1 timing, latches address/R/W in Phi1,
// takes spaced data samples in Phi0 and reports glitches, cycles and sleep.
module a2bus_sampler #(
    parameter int PC_W            = 6,
    parameter int ADDR_COUNT      = 18,
    parameter int DATA_COUNT      = 15,
    parameter int NUM_SAMPLES     = 3,
    parameter int SAMPLE_SPACING  = 2,
    parameter int MIN_PHASE_COUNT = 20
) (
    input  logic      clk_logic_i,
    input  logic      system_reset_i,
    a2bus_sampler_if.slave bus
);

    localparam int LAST_COUNT = DATA_COUNT + (NUM_SAMPLES - 1) * SAMPLE_SPACING;
    localparam int PC_MAX_INT = (1 << PC_W) - 1;
    localparam logic [PC_W-1:0] PC_MAX = '1;

    generate
        if (NUM_SAMPLES < 1 || NUM_SAMPLES > 4 || SAMPLE_SPACING < 1 ||
            ADDR_COUNT >= PC_MAX_INT || LAST_COUNT >= PC_MAX_INT ||
            ADDR_COUNT >= MIN_PHASE_COUNT || LAST_COUNT >= MIN_PHASE_COUNT) begin : g_bad_params
            $error("a2bus_sampler: sample counts out of legal range");
        end
    endgenerate

    logic            phi1_r;
    logic [PC_W-1:0] pc;
    logic            edge_w;
    logic            sleep;
    logic            addr_hit;
    logic            sample_hit;
    logic            sample_first;
    logic            sample_last;
    logic            glitch_hit;

    logic [15:0] addr;
    logic        rw_n;
    logic        addr_strobe;
    logic [7:0]  data;
    logic        data_strobe;
    logic        data_stable;
    logic [7:0]  ref_data;
    logic        match;
    logic        glitch;
    logic [7:0]  glitch_count;
    logic [31:0] cycle_count;

    // The phase register runs through reset so the first edge after release is seen correctly.
    always_ff @(posedge clk_logic_i) begin
        phi1_r <= bus.a2_phi1_i;
    end

    assign edge_w     = bus.a2_phi1_i ^ phi1_r;
    assign sleep      = (pc == PC_MAX);
    assign addr_hit   = phi1_r && !edge_w && (pc == PC_W'(ADDR_COUNT));
    assign glitch_hit = edge_w && !sleep && (32'(pc) < MIN_PHASE_COUNT);

    // An edge landing on a sample count wins, so samples are gated by !edge_w.
    always_comb begin
        sample_hit   = 1'b0;
        sample_first = 1'b0;
        sample_last  = 1'b0;
        if (!phi1_r && !edge_w) begin
            for (int k = 0; k < NUM_SAMPLES; k++) begin
                if (pc == PC_W'(DATA_COUNT + k * SAMPLE_SPACING)) begin
                    sample_hit = 1'b1;
                    if (k == 0) sample_first = 1'b1;
                    if (k == NUM_SAMPLES - 1) sample_last = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_logic_i) begin
        if (system_reset_i) begin
            pc           <= PC_MAX;
            addr         <= '0;
            rw_n         <= 1'b1;
            addr_strobe  <= 1'b0;
            data         <= '0;
            data_strobe  <= 1'b0;
            data_stable  <= 1'b0;
            ref_data     <= '0;
            match        <= 1'b0;
            glitch       <= 1'b0;
            glitch_count <= '0;
            cycle_count  <= '0;
        end else begin
            if (edge_w)
                pc <= '0;
            else if (!sleep)
                pc <= pc + 1'b1;

            addr_strobe <= addr_hit;
            if (addr_hit) begin
                addr <= bus.a2_a_i;
                rw_n <= bus.a2_rw_n_i;
            end

            data_strobe <= sample_hit && sample_last;
            if (sample_hit) begin
                if (sample_first) begin
                    ref_data <= bus.a2_d_i;
                    match    <= 1'b1;
                end else if (bus.a2_d_i != ref_data) begin
                    match <= 1'b0;
                end
                if (sample_last) begin
                    if (!rw_n)
                        data <= bus.a2_d_i;
                    data_stable <= sample_first ? 1'b1 : (match && (bus.a2_d_i == ref_data));
                end
            end

            glitch <= glitch_hit;
            if (glitch_hit && glitch_count != 8'hFF)
                glitch_count <= glitch_count + 8'd1;

            if (edge_w && bus.a2_phi1_i)
                cycle_count <= cycle_count + 32'd1;
        end
    end

    assign bus.addr_o           = addr;
    assign bus.rw_n_o           = rw_n;
    assign bus.addr_strobe_o    = addr_strobe;
    assign bus.data_o           = data;
    assign bus.data_in_strobe_o = data_strobe;
    assign bus.data_stable_o    = data_stable;
    assign bus.glitch_o         = glitch;
    assign bus.glitch_count_o   = glitch_count;
    assign bus.cycle_count_o    = cycle_count;
    assign bus.phase_o          = phi1_r;
    assign bus.sleep_o          = sleep;

endmodule
